l2_icache_responder: RTL and testbench

// L2-side responder for the icache<->L2 request interface: accepts one icache op at a time
// (R, W, RWITM, FLUSH, UPDATE), models a line-granular backing store with fixed access

---
 rtl/l2_icache_responder_if.sv | 26 ++
 rtl/l2_icache_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_l2_icache_responder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_icache_responder_if.sv
// Request/response bundle between the icache and the L2-side responder.
// master = icache side, slave = L2 responder.
interface l2_icache_responder_if #(
    parameter int LINE_BITS = 512
);
    logic [2:0]           icache_l2_op;
    logic [31:0]          icache_l2_addr;
    logic [LINE_BITS-1:0] icache_l2_data_in;
    logic [1:0]           icache_l2_state;

    logic                 l2_icache_ready;
    logic [2:0]           l2_icache_op;
    logic [31:0]          l2_icache_addr;
    logic [LINE_BITS-1:0] l2_icache_data;
    logic [1:0]           l2_icache_state;

    modport master (
        output icache_l2_op, icache_l2_addr, icache_l2_data_in, icache_l2_state,
        input  l2_icache_ready, l2_icache_op, l2_icache_addr, l2_icache_data, l2_icache_state
    );

    modport slave (
        input  icache_l2_op, icache_l2_addr, icache_l2_data_in, icache_l2_state,
        output l2_icache_ready, l2_icache_op, l2_icache_addr, l2_icache_data, l2_icache_state
    );
endinterface

// File: rtl/l2_icache_responder.sv
// L2-side responder for icache requests: one outstanding op, fixed-latency line store.
// Optional next-line prefetch buffer enabled by defining L2_ICACHE_NEXTLINE_PF_EN.
module l2_icache_responder #(
    parameter int LINE_BYTES = 64,
    parameter int MEM_LINES  = 256,
    parameter int LATENCY    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    l2_icache_responder_if.slave bus
);
    localparam int LINE_BITS = 8 * LINE_BYTES;
    localparam int OFF       = $clog2(LINE_BYTES);
    localparam int IDXW      = $clog2(MEM_LINES);
    localparam int CNTW      = $clog2(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} fsm_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_R      = 3'b001,
        OP_W      = 3'b010,
        OP_RWITM  = 3'b011,
        OP_FLUSH  = 3'b100,
        OP_UPDATE = 3'b101
    } req_op_t;

    localparam logic [2:0] RSP_NOP  = 3'b000;
    localparam logic [2:0] RSP_DATA = 3'b001;
    localparam logic [2:0] RSP_ACK  = 3'b010;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    fsm_t                 fsm;
    logic [CNTW-1:0]      cnt;
    req_op_t              req_op;
    logic [31:0]          req_addr;
    logic [LINE_BITS-1:0] req_data;
    logic [1:0]           req_state;
    logic [IDXW-1:0]      req_idx;

    logic                 ready_q;
    logic [2:0]           rsp_op;
    logic [31:0]          rsp_addr;
    logic [LINE_BITS-1:0] rsp_data;
    logic [1:0]           rsp_state;

    logic [2:0]           nxt_op;
    logic [LINE_BITS-1:0] nxt_data;
    logic [1:0]           nxt_state;

    logic [LINE_BITS-1:0] data_mem  [MEM_LINES];
    logic [1:0]           state_mem [MEM_LINES];

    logic [31:0]          in_aligned;
    logic                 accept;
    logic                 speculative;
    logic                 kill;
    logic                 pf_hit;

    assign in_aligned  = bus.icache_l2_addr & ~32'(LINE_BYTES - 1);
    assign accept      = (fsm == IDLE) && ready_q && (bus.icache_l2_op != OP_NOP) && !flush;
    assign req_idx     = req_addr[OFF+IDXW-1:OFF];
    assign speculative = (req_op == OP_R) || (req_op == OP_RWITM);
    // A resteer kills a pending read anywhere after accept, including the pulse cycle itself.
    assign kill        = flush && speculative && (fsm != IDLE);

`ifdef L2_ICACHE_NEXTLINE_PF_EN
    logic                 pf_valid;
    logic [31:0]          pf_addr;
    logic [LINE_BITS-1:0] pf_data;
    logic [31:0]          next_addr;
    logic [IDXW-1:0]      next_idx;

    assign next_addr = req_addr + 32'(LINE_BYTES);
    assign next_idx  = next_addr[OFF+IDXW-1:OFF];
    assign pf_hit    = pf_valid && (bus.icache_l2_op == OP_R) && (in_aligned == pf_addr);

    // Refill after every completed read; any modifying op to the buffered line invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_valid <= 1'b0;
            pf_addr  <= '0;
            pf_data  <= '0;
        end else if (fsm == RESP && req_op == OP_R && !kill) begin
            pf_valid <= 1'b1;
            pf_addr  <= next_addr;
            pf_data  <= data_mem[next_idx];
        end else if (accept && bus.icache_l2_op != OP_R && in_aligned == pf_addr) begin
            pf_valid <= 1'b0;
        end
    end
`else
    assign pf_hit = 1'b0;
`endif

    always_comb begin
        nxt_op    = RSP_ACK;
        nxt_data  = '0;
        nxt_state = ST_I;
        case (req_op)
            OP_R: begin
                nxt_op    = RSP_DATA;
                nxt_data  = data_mem[req_idx];
                nxt_state = ST_E;
            end
            OP_RWITM: begin
                nxt_op    = RSP_DATA;
                nxt_data  = data_mem[req_idx];
                nxt_state = ST_M;
            end
            OP_W, OP_UPDATE: nxt_state = req_state;
            default: ;
        endcase
    end

    // Response registers load on the edge entering RESP and clear on the edge leaving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b1;
            req_op    <= OP_NOP;
            req_addr  <= '0;
            req_data  <= '0;
            req_state <= ST_I;
            rsp_op    <= RSP_NOP;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_state <= ST_I;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        req_op    <= req_op_t'(bus.icache_l2_op);
                        req_addr  <= in_aligned;
                        req_data  <= bus.icache_l2_data_in;
                        req_state <= bus.icache_l2_state;
                        ready_q   <= 1'b0;
`ifdef L2_ICACHE_NEXTLINE_PF_EN
                        if (pf_hit) begin
                            fsm       <= RESP;
                            rsp_op    <= RSP_DATA;
                            rsp_addr  <= in_aligned;
                            rsp_data  <= pf_data;
                            rsp_state <= ST_E;
                        end else begin
                            fsm <= WAIT;
                            cnt <= CNTW'(LATENCY - 1);
                        end
`else
                        fsm <= WAIT;
                        cnt <= CNTW'(LATENCY - 1);
`endif
                    end
                end
                WAIT: begin
                    if (kill) begin
                        fsm     <= IDLE;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                    end else if (cnt == CNTW'(1)) begin
                        fsm       <= RESP;
                        cnt       <= '0;
                        rsp_op    <= nxt_op;
                        rsp_addr  <= req_addr;
                        rsp_data  <= nxt_data;
                        rsp_state <= nxt_state;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                RESP: begin
                    fsm       <= IDLE;
                    ready_q   <= 1'b1;
                    rsp_op    <= RSP_NOP;
                    rsp_addr  <= '0;
                    rsp_data  <= '0;
                    rsp_state <= ST_I;
                end
                default: begin
                    fsm     <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Coherence state commits at the end of the response cycle unless the read was killed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_LINES; i++) begin
                state_mem[i] <= ST_I;
            end
        end else if (fsm == RESP && !kill) begin
            case (req_op)
                OP_R:            state_mem[req_idx] <= ST_E;
                OP_RWITM:        state_mem[req_idx] <= ST_M;
                OP_W, OP_UPDATE: state_mem[req_idx] <= req_state;
                OP_FLUSH:        state_mem[req_idx] <= ST_I;
                default: ;
            endcase
        end
    end

    // Data store is deliberately not reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (fsm == RESP && req_op == OP_W) begin
            data_mem[req_idx] <= req_data;
        end
    end

    assign bus.l2_icache_ready = ready_q;
    assign bus.l2_icache_op    = kill ? RSP_NOP : rsp_op;
    assign bus.l2_icache_addr  = kill ? 32'h0 : rsp_addr;
    assign bus.l2_icache_data  = kill ? '0 : rsp_data;
    assign bus.l2_icache_state = kill ? ST_I : rsp_state;
endmodule

// File: tb/tb_l2_icache_responder.sv
// Scoreboard bench for l2_icache_responder; expected responses are queued at accept time.
// Build with L2_ICACHE_NEXTLINE_PF_EN defined to exercise the next-line buffer.
module tb_l2_icache_responder;
    localparam int LINE_BITS = 512;
    localparam int LAT       = 4;
`ifdef L2_ICACHE_NEXTLINE_PF_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 4;
`endif

    localparam logic [2:0] R = 3'b001, W = 3'b010, RWITM = 3'b011, UPD = 3'b101;
    localparam logic [2:0] DATA = 3'b001, ACK = 3'b010;

    typedef struct {
        logic [2:0]           op;
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
        logic [1:0]           state;
        int                   cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    rsp_t exp_q[$];
    rsp_t obs_q[$];

    l2_icache_responder_if #(.LINE_BITS(LINE_BITS)) bus();

    l2_icache_responder dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rsp_t r;
        if (bus.l2_icache_op !== 3'b000) begin
            r.op = bus.l2_icache_op;
            r.addr = bus.l2_icache_addr;
            r.data = bus.l2_icache_data;
            r.state = bus.l2_icache_state;
            r.cyc = cyc;
            obs_q.push_back(r);
        end
    end

    function automatic logic [LINE_BITS-1:0] pat(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [LINE_BITS-1:0] d, input logic [1:0] st, output int acc);
        int n = 0;
        @(negedge clk);
        bus.icache_l2_op = op;
        bus.icache_l2_addr = addr;
        bus.icache_l2_data_in = d;
        bus.icache_l2_state = st;
        while (bus.l2_icache_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) $display("[TB] FAIL accept_timeout addr=%h ready=%b required 1", addr, bus.l2_icache_ready);
        else passes++;
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.icache_l2_op = 3'b000;
        bus.icache_l2_addr = '0;
        bus.icache_l2_data_in = '0;
        bus.icache_l2_state = 2'b00;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [31:0] addr,
                            input logic [LINE_BITS-1:0] d, input logic [1:0] st, input int due);
        rsp_t e;
        e.op = op; e.addr = addr; e.data = d; e.state = st; e.cyc = due;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int acc;
        bus.icache_l2_op = 3'b000;
        bus.icache_l2_addr = '0;
        bus.icache_l2_data_in = '0;
        bus.icache_l2_state = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.l2_icache_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b required 1", bus.l2_icache_ready);
        else passes++;
        checks++;
        if ({bus.l2_icache_op, bus.l2_icache_addr, bus.l2_icache_state, bus.l2_icache_data} !== '0)
            $display("[TB] FAIL reset_outputs op=%0d addr=%h state=%0d required all 0",
                     bus.l2_icache_op, bus.l2_icache_addr, bus.l2_icache_state);
        else passes++;
        issue(R, 32'h100, '0, 2'b00, acc);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.l2_icache_ready !== 1'b1) $display("[TB] FAIL midwait_reset_ready got=%b required 1", bus.l2_icache_ready);
        else passes++;
        repeat (8) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) $display("[TB] FAIL midwait_reset_noresp got=%0d responses required 0", obs_q.size());
        else passes++;
        obs_q.delete();
    endtask

    task automatic test_write_read();
        int acc;
        rsp_t e, o;
        issue(W, 32'h1000, pat(32'hA5A5A5A5), 2'b11, acc);
        push_exp(ACK, 32'h1000, '0, 2'b11, acc + LAT - 1);
        idle();
        issue(R, 32'h1010, '0, 2'b00, acc);
        push_exp(DATA, 32'h1000, pat(32'hA5A5A5A5), 2'b10, acc + LAT - 1);
        idle();
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL wr_rd_missing got none required op=%0d addr=%h", e.op, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.op !== e.op || o.addr !== e.addr || o.state !== e.state || o.cyc != e.cyc)
                    $display("[TB] FAIL wr_rd_rsp got op=%0d addr=%h st=%0d cyc=%0d required op=%0d addr=%h st=%0d cyc=%0d",
                             o.op, o.addr, o.state, o.cyc, e.op, e.addr, e.state, e.cyc);
                else passes++;
                checks++;
                if (o.data !== e.data) $display("[TB] FAIL wr_rd_data got=%h required=%h", o.data[63:0], e.data[63:0]);
                else passes++;
            end
        end
    endtask

    task automatic test_flush();
        int acc;
        rsp_t e, o;
        issue(R, 32'h2000, '0, 2'b00, acc);
        idle();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (bus.l2_icache_ready !== 1'b1) $display("[TB] FAIL flush_abort_ready got=%b required 1", bus.l2_icache_ready);
        else passes++;
        bus.icache_l2_op = R;
        bus.icache_l2_addr = 32'h2040;
        flush = 1'b1;
        @(negedge clk);
        bus.icache_l2_op = 3'b000;
        flush = 1'b0;
        checks++;
        if (bus.l2_icache_ready !== 1'b1) $display("[TB] FAIL flush_same_cycle_ready got=%b required 1", bus.l2_icache_ready);
        else passes++;
        issue(R, 32'h1000, '0, 2'b00, acc);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) $display("[TB] FAIL flush_noresp got=%0d responses required 0", obs_q.size());
        else passes++;
        obs_q.delete();
        issue(UPD, 32'h2000, '0, 2'b01, acc);
        push_exp(ACK, 32'h2000, '0, 2'b01, acc + LAT - 1);
        idle();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL flush_update_missing got none required op=%0d addr=%h", e.op, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.op !== e.op || o.addr !== e.addr || o.state !== e.state || o.cyc != e.cyc)
                    $display("[TB] FAIL flush_update_rsp got op=%0d addr=%h st=%0d cyc=%0d required op=%0d addr=%h st=%0d cyc=%0d",
                             o.op, o.addr, o.state, o.cyc, e.op, e.addr, e.state, e.cyc);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, acc2;
        rsp_t e, o;
        issue(W, 32'h0, pat(32'h11111111), 2'b01, acc);
        push_exp(ACK, 32'h0, '0, 2'b01, acc + LAT - 1);
        issue(W, 32'h40, pat(32'h22222222), 2'b10, acc);
        push_exp(ACK, 32'h40, '0, 2'b10, acc + LAT - 1);
        issue(R, 32'h0, '0, 2'b00, acc);
        push_exp(DATA, 32'h0, pat(32'h11111111), 2'b10, acc + LAT - 1);
        issue(R, 32'h40, '0, 2'b00, acc2);
        push_exp(DATA, 32'h40, pat(32'h22222222), 2'b10, acc2 + HIT_LAT - 1);
        idle();
        checks++;
        if (acc2 != acc + LAT + 1) $display("[TB] FAIL b2b_accept_gap got=%0d required=%0d", acc2 - acc, LAT + 1);
        else passes++;
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL b2b_missing got none required op=%0d addr=%h", e.op, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.op !== e.op || o.addr !== e.addr || o.state !== e.state || o.cyc != e.cyc)
                    $display("[TB] FAIL b2b_rsp got op=%0d addr=%h st=%0d cyc=%0d required op=%0d addr=%h st=%0d cyc=%0d",
                             o.op, o.addr, o.state, o.cyc, e.op, e.addr, e.state, e.cyc);
                else passes++;
                checks++;
                if (o.data !== e.data) $display("[TB] FAIL b2b_data got=%h required=%h", o.data[63:0], e.data[63:0]);
                else passes++;
            end
        end
    endtask

    task automatic test_wrap();
        int acc;
        rsp_t e, o;
        issue(W, 32'h0, pat(32'h5A5A0000), 2'b10, acc);
        push_exp(ACK, 32'h0, '0, 2'b10, acc + LAT - 1);
        issue(RWITM, 32'h4000, '0, 2'b00, acc);
        push_exp(DATA, 32'h4000, pat(32'h5A5A0000), 2'b11, acc + LAT - 1);
        issue(R, 32'h4000, '0, 2'b00, acc);
        push_exp(DATA, 32'h4000, pat(32'h5A5A0000), 2'b10, acc + LAT - 1);
        idle();
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL wrap_missing got none required op=%0d addr=%h", e.op, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.op !== e.op || o.addr !== e.addr || o.state !== e.state || o.cyc != e.cyc)
                    $display("[TB] FAIL wrap_rsp got op=%0d addr=%h st=%0d cyc=%0d required op=%0d addr=%h st=%0d cyc=%0d",
                             o.op, o.addr, o.state, o.cyc, e.op, e.addr, e.state, e.cyc);
                else passes++;
                checks++;
                if (o.data !== e.data) $display("[TB] FAIL wrap_data got=%h required=%h", o.data[63:0], e.data[63:0]);
                else passes++;
            end
        end
    endtask

    task automatic test_prefetch();
        int acc;
        rsp_t e, o;
        issue(W, 32'h3000, pat(32'h30003000), 2'b01, acc);
        push_exp(ACK, 32'h3000, '0, 2'b01, acc + LAT - 1);
        issue(W, 32'h3040, pat(32'h30403040), 2'b01, acc);
        push_exp(ACK, 32'h3040, '0, 2'b01, acc + LAT - 1);
        issue(R, 32'h3000, '0, 2'b00, acc);
        push_exp(DATA, 32'h3000, pat(32'h30003000), 2'b10, acc + LAT - 1);
        idle();
        issue(R, 32'h3040, '0, 2'b00, acc);
        push_exp(DATA, 32'h3040, pat(32'h30403040), 2'b10, acc + HIT_LAT - 1);
        idle();
        issue(W, 32'h3080, pat(32'h30803080), 2'b11, acc);
        push_exp(ACK, 32'h3080, '0, 2'b11, acc + LAT - 1);
        idle();
        issue(R, 32'h3080, '0, 2'b00, acc);
        push_exp(DATA, 32'h3080, pat(32'h30803080), 2'b10, acc + LAT - 1);
        idle();
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL pf_missing got none required op=%0d addr=%h", e.op, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.op !== e.op || o.addr !== e.addr || o.state !== e.state || o.cyc != e.cyc)
                    $display("[TB] FAIL pf_rsp got op=%0d addr=%h st=%0d cyc=%0d required op=%0d addr=%h st=%0d cyc=%0d",
                             o.op, o.addr, o.state, o.cyc, e.op, e.addr, e.state, e.cyc);
                else passes++;
                checks++;
                if (o.data !== e.data) $display("[TB] FAIL pf_data got=%h required=%h", o.data[63:0], e.data[63:0]);
                else passes++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_flush();
        test_back_to_back();
        test_wrap();
        test_prefetch();
        checks++;
        if (obs_q.size() != 0) $display("[TB] FAIL stray_responses got=%0d required 0", obs_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
